// File: rtl/shift_add_multiplier_pkg.sv
// Shared widths and FSM encoding for the sequential shift-and-add multiplier.
package shift_add_multiplier_pkg;

    localparam int WIDTH  = 4;
    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational WIDTH-bit ripple-carry adder; zero latency, no flow control.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin
);

    logic carry;

    always_comb begin
        S     = '0;
        carry = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier; 4 iterations, done pulses one cycle after the last.
// No backpressure: start is honoured only in IDLE and ignored while busy or done.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;

    assign addend = q_q[0] ? m_q : '0;

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .S    (sum),
        .Cout (cout),
        .A    (acc_q),
        .B    (addend),
        .Cin  (1'b0)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // The adder carry becomes the new ACC msb, so 15*15 never overflows.
                acc_d   = {cout, sum[WIDTH-1:1]};
                q_d     = {sum[0], q_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = ST_DONE;
                    product_d = {acc_d, q_d};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: expected products queued at start, checked at done.
module tb_shift_add_multiplier;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    logic [7:0] exp_q[$];
    int         n_vec;
    int         n_err;

    shift_add_multiplier #(
        .WIDTH (4),
        .CNT_W (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [3:0] ta, input logic [3:0] tbv);
        @(negedge clk);
        a     = ta;
        b     = tbv;
        start = 1'b1;
        exp_q.push_back({4'h0, ta} * {4'h0, tbv});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'h0;
        b     = 4'h0;
        #1;
        n_vec++;
        if ({busy, done, product} !== 10'h000) begin
            $display("FAIL reset_async: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
            n_err++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy, done, product} !== 10'h000) begin
            $display("FAIL reset_idle: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
            n_err++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] expv;
        start_op(4'h5, 4'h3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || product !== 8'h00) begin
                $display("FAIL basic_run[%0d]: busy=%b done=%b product=%h, required 1 0 00", i, busy, done, product);
                n_err++;
            end
        end
        @(negedge clk);
        expv = exp_q.pop_front();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== expv) begin
            $display("FAIL basic_done: done=%b busy=%b product=%h, required 1 0 %h", done, busy, product, expv);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== expv) begin
            $display("FAIL basic_after: done=%b busy=%b product=%h, required 0 0 %h", done, busy, product, expv);
            n_err++;
        end
    endtask

    task automatic test_cout_hold();
        int         cyc;
        logic       held_ok;
        logic [7:0] expv;
        start_op(4'hF, 4'hF);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        expv = exp_q.pop_front();
        n_vec++;
        if (done !== 1'b1 || product !== expv) begin
            $display("FAIL cout_ff: done=%b product=%h, required 1 %h", done, product, expv);
            n_err++;
        end
        start_op(4'h0, 4'hB);
        cyc     = 0;
        held_ok = 1'b1;
        while (done !== 1'b1 && cyc < 20) begin
            if (product !== 8'hE1) held_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (held_ok !== 1'b1) begin
            $display("FAIL hold_e1: product changed mid-operation, required e1 until completion");
            n_err++;
        end
        expv = exp_q.pop_front();
        n_vec++;
        if (done !== 1'b1 || product !== expv) begin
            $display("FAIL zero_mult: done=%b product=%h, required 1 %h", done, product, expv);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int         cyc;
        logic [7:0] expv;
        start_op(4'h9, 4'h7);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        expv = exp_q.pop_front();
        n_vec++;
        if (done !== 1'b1 || product !== expv) begin
            $display("FAIL b2b_first: done=%b product=%h, required 1 %h", done, product, expv);
            n_err++;
        end
        // Start raised during DONE and held: ignored in DONE, accepted on the next IDLE edge.
        a     = 4'h2;
        b     = 4'h8;
        start = 1'b1;
        exp_q.push_back(8'h10);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL b2b_done_ignore: busy=%b done=%b, required 0 0", busy, done);
            n_err++;
        end
        @(negedge clk);
        start = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        n_vec++;
        if (busy !== 1'b1 || product !== 8'h3F) begin
            $display("FAIL b2b_accept: busy=%b product=%h, required 1 3f", busy, product);
            n_err++;
        end
        @(negedge clk);
        start = 1'b1;
        a     = 4'h1;
        b     = 4'h1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expv = exp_q.pop_front();
        n_vec++;
        if (done !== 1'b1 || product !== expv) begin
            $display("FAIL b2b_second: done=%b product=%h, required 1 %h", done, product, expv);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== expv) begin
            $display("FAIL b2b_idle: busy=%b done=%b product=%h, required 0 0 %h", busy, done, product, expv);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        int         cyc;
        logic [7:0] expv;
        start_op(4'h6, 4'h7);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            $display("FAIL reset_mid: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
            n_err++;
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            $display("FAIL reset_mid_hold: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
            n_err++;
        end
        rst_n = 1'b1;
        start_op(4'h3, 4'h3);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        expv = exp_q.pop_front();
        n_vec++;
        if (done !== 1'b1 || product !== expv) begin
            $display("FAIL reset_recover: done=%b product=%h, required 1 %h", done, product, expv);
            n_err++;
        end
    endtask

    task automatic test_sweep();
        int         cyc;
        logic       overlap;
        logic [7:0] expv;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                start_op(4'(ia), 4'(ib));
                cyc     = 0;
                overlap = 1'b0;
                while (done !== 1'b1 && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                    if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
                end
                expv = exp_q.pop_front();
                n_vec++;
                if (done !== 1'b1 || product !== expv || cyc != 4 || overlap !== 1'b0) begin
                    $display("FAIL sweep %0d*%0d: product=%h cycles=%0d overlap=%b, required %h 4 0",
                             ia, ib, product, cyc, overlap, expv);
                    n_err++;
                end
                @(negedge clk);
                n_vec++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    $display("FAIL sweep_pulse %0d*%0d: done=%b busy=%b, required 0 0", ia, ib, done, busy);
                    n_err++;
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_cout_hold();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        n_vec++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
